// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller bank: FSM states, value width
// and the active-low seven-segment digit table (bit 6 = g).
package dice_pkg;

  localparam int VAL_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SHOW    = 2'd2
  } dice_state_e;

  localparam logic [6:0] DIGIT_SEG [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h18
  };

endpackage

// File: rtl/dice_roller_bank_if.sv
// Control and display bundle between the button/switch side (master) and the
// dice roller bank (slave).
interface dice_roller_bank_if #(
  parameter int NUM_DICE = 2
);
  // roll is a level; only its rising edge starts a roll, and edges seen while
  // busy are dropped. busy covers the animation phase, done pulses for one cycle
  // when die_val/sum latch, and those values stay valid until the next roll.
  logic                                 roll;
  logic [dice_pkg::VAL_W-1:0]           sides;
  logic                                 busy;
  logic                                 done;
  logic [dice_pkg::VAL_W*NUM_DICE-1:0]  die_val;
  logic [8:0]                           sum;
  logic [7*NUM_DICE-1:0]                seg_tens;
  logic [7*NUM_DICE-1:0]                seg_units;
  dice_pkg::dice_state_e                state;

  modport master (
    output roll, sides,
    input  busy, done, die_val, sum, seg_tens, seg_units, state
  );

  modport slave (
    input  roll, sides,
    output busy, done, die_val, sum, seg_tens, seg_units, state
  );
endinterface

// File: rtl/dice_seg_decode.sv
// Splits a 0..99 die value into tens and units digits and maps each onto the
// active-low seven-segment pattern.
module dice_seg_decode
  import dice_pkg::*;
(
  input  logic [VAL_W-1:0] val,
  output logic [6:0]       tens,
  output logic [6:0]       units
);

  logic [VAL_W-1:0] tens_n;
  logic [3:0]       units_n;

  always_comb begin
    tens_n  = val / 7'd10;
    units_n = 4'(val % 7'd10);
    // Values above 99 never reach here; the clamp only keeps the index in range.
    tens    = DIGIT_SEG[(tens_n > 7'd9) ? 4'd9 : tens_n[3:0]];
    units   = DIGIT_SEG[units_n];
  end

endmodule

// File: rtl/dice_roller_bank.sv
// Multi-die roller: odometer counters chained across dice, a fixed-length
// animation phase, then latched results, a total and a one-cycle done pulse.
module dice_roller_bank
  import dice_pkg::*;
#(
  parameter int NUM_DICE    = 2,
  parameter int MAX_SIDES   = 20,
  parameter int ANIM_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  dice_roller_bank_if.slave   bus
);

  localparam int               AW        = $clog2(ANIM_CYCLES + 1);
  localparam logic [AW-1:0]    ANIM_LOAD = AW'(ANIM_CYCLES - 1);
  localparam logic [VAL_W-1:0] MAX_S     = VAL_W'(MAX_SIDES);

  dice_state_e      state;
  logic             roll_q;
  logic             start;
  logic             latch;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    anim;
  logic [VAL_W-1:0] sides_q;
  logic [VAL_W-1:0] sides_clamped;
  logic [VAL_W-1:0] cnt      [NUM_DICE];
  logic [VAL_W-1:0] cnt_next [NUM_DICE];
  logic [VAL_W-1:0] res      [NUM_DICE];
  logic [8:0]       sum_q;
  logic [8:0]       sum_next;

  assign start = bus.roll & ~roll_q;
  assign latch = (state == ROLLING) && (anim == '0);

  always_comb begin
    sides_clamped = bus.sides;
    if (bus.sides < 7'd2)       sides_clamped = 7'd2;
    else if (bus.sides > MAX_S) sides_clamped = MAX_S;
  end

  // Odometer: a die advances only when every lower die wraps this cycle. The
  // >= wrap test also pulls stale values back to 1 after sides_q shrinks.
  always_comb begin : odometer
    logic carry;
    carry    = 1'b1;
    sum_next = '0;
    for (int k = 0; k < NUM_DICE; k++) begin
      cnt_next[k] = cnt[k];
      if (carry) cnt_next[k] = (cnt[k] >= sides_q) ? 7'd1 : cnt[k] + 7'd1;
      carry    = carry & (cnt[k] >= sides_q);
      sum_next = sum_next + 9'(cnt_next[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      roll_q  <= 1'b0;
      sides_q <= MAX_S;
      anim    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= 9'(NUM_DICE);
      for (int k = 0; k < NUM_DICE; k++) begin
        cnt[k] <= 7'd1;
        res[k] <= 7'd1;
      end
    end else begin
      roll_q <= bus.roll;
      done_q <= 1'b0;
      for (int k = 0; k < NUM_DICE; k++) cnt[k] <= cnt_next[k];
      case (state)
        IDLE, SHOW: begin
          if (start) begin
            state   <= ROLLING;
            anim    <= ANIM_LOAD;
            busy_q  <= 1'b1;
            sides_q <= sides_clamped;
          end
        end
        ROLLING: begin
          if (latch) begin
            state  <= SHOW;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= sum_next;
            for (int k = 0; k < NUM_DICE; k++) res[k] <= cnt_next[k];
          end else begin
            anim <= anim - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.state = state;

  for (genvar k = 0; k < NUM_DICE; k++) begin : g_die
    logic [VAL_W-1:0] disp;
    assign disp = (state == ROLLING) ? cnt[k] : res[k];
    assign bus.die_val[VAL_W*k +: VAL_W] = disp;
    dice_seg_decode u_seg (
      .val   (disp),
      .tens  (bus.seg_tens[7*k +: 7]),
      .units (bus.seg_units[7*k +: 7])
    );
  end

endmodule

// File: doc/dice_roller_bank.md
# dice_roller_bank

Parametrised multi-die roller for the board-level dice projects. It supports a runtime-selectable side count of up to 99 and drives one pair of seven-segment digits per die. A roll runs a fixed-length animation phase, then latches results, a total and a one-cycle done pulse. It sits between the debounced roll button/side-select switches and the display pins.

## Interface
- NUM_DICE, default 2: number of dice, legal range 1–4.
- MAX_SIDES, default 20: upper clamp on side count, legal range 2–99.
- ANIM_CYCLES, default 8: length of the ROLLING phase in clock cycles, must be ≥ 1.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- roll  in  1  roll request, level input; only the rising edge acts.
- sides  in  7  requested side count, sampled at roll start.
- busy  out  1  high while in ROLLING.
- done  out  1  one-cycle pulse when results latch.
- die_val  out  7*NUM_DICE  die k is at bits [7k+6:7k], binary 1..sides_q.
- sum  out  9  sum of the latched die values.
- seg_tens  out  7*NUM_DICE  tens digit per die, active-low, bit 6 = g.
- seg_units  out  7*NUM_DICE  units digit per die, same encoding.

## Operation
- Rising-edge detect: a 1-cycle roll_q register; start = roll & ~roll_q.
- FSM states:
  - IDLE → ROLLING on start.
  - ROLLING → SHOW when the anim counter reaches 0.
  - SHOW → ROLLING on start.
  - start is ignored in ROLLING; it does not extend or restart the phase.
- sides_q is registered at start, clamped:
  - < 2 → 2.
  - > MAX_SIDES → MAX_SIDES.
  - Reset value is MAX_SIDES.
- Free-running odometer counters cnt[k], 7 bits each, step every cycle in all states:
  - Die 0 steps every cycle.
  - Die k steps when die k-1 steps and cnt[k-1] ≥ sides_q.
  - Step rule: cnt ≥ sides_q → 1, else cnt+1. This also pulls any out-of-range value back to 1 after a side-count decrease.
- Display source:
  - In ROLLING, die_val/segments show live cnt[k] (animation).
  - In IDLE and SHOW they show latched res[k].
- Latch: on the ROLLING→SHOW edge, res[k] ← cnt[k] as stepped that same cycle; the sum register is loaded from the same values; done=1 for exactly that one following cycle.
- sum always reflects res, never live counters; it is 9 bits wide (max 4*99 = 396).
- Digit encoding (active-low): 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=18h.
  - Tens digit for values < 10 shows 0 (40h).
  - Values ≥ 100 cannot occur.
- Reset values:
  - state IDLE, roll_q 0, sides_q MAX_SIDES.
  - all cnt and res = 1.
  - busy 0, done 0, sum = NUM_DICE.
  - every seg_tens = 40h, every seg_units = 79h.

## Timing
- The start edge enters ROLLING on the next clock; busy is high from that cycle for exactly ANIM_CYCLES cycles.
- done rises in the first SHOW cycle, simultaneously with busy falling; res and sum are valid in that same cycle.
- Roll-to-result latency: ANIM_CYCLES+1 clocks from the clock that samples roll high.
- A roll held high produces exactly one roll. A new edge arriving in the done cycle is honoured: ROLLING re-entered next clock.
- reset wins over all events, including mid-ROLLING: return to IDLE and reset values, with no done pulse.
- A sides change outside a start edge has no effect until the next roll.
- Segment outputs are combinational from registered values; there are no glitch requirements beyond that.

## Structure
- Package dice_pkg holds:
  - the state enum (IDLE, ROLLING, SHOW);
  - the 10-entry digit-encoding constant array;
  - a localparam VAL_W=7.
- Sub-module dice_seg_decode takes a 7-bit value and outputs the tens/units 7-bit active-low digits, via divide-by-10 logic on 0..99. Instantiate one per die in a generate loop.
- Top module holds the FSM, the animation counter ($clog2(ANIM_CYCLES+1) bits), the odometer counters, the result registers and the sum adder.

## Test plan
- Reset with NUM_DICE=2 → die_val all 1, sum=2, seg_tens=40h/40h, seg_units=79h/79h, busy=0, done=0.
- sides=6, roll pulse, ANIM_CYCLES=8 → busy high exactly 8 cycles, single done pulse; every result is in 1..6; sum equals die0+die1 and matches a cycle-accurate odometer reference model.
- sides=0 then sides=120 with MAX_SIDES=20:
  - sides=0 → results only 1..2.
  - sides=120 → results only 1..20.
  - A forced result of 20 displays tens=24h, units=40h.
- roll held high 50 cycles → exactly one done pulse; a second edge during ROLLING is ignored, and the done count stays 1.
- reset asserted on cycle 3 of ROLLING → next cycle IDLE, all reset values restored, no done pulse; a later roll works normally.
- Re-roll from SHOW with sides lowered from 20 to 4 while a counter holds 17 → that counter reads 1 on the next step, and all subsequent values are 1..4.
